// File: rtl/fifo_vc.sv
// fifo_vc: single-clock FIFO for one virtual channel.
// Occupancy is tracked with a separate count. Status flags are decoded
// combinationally from the registered count. Read data is registered.
// FIFO_error is a sticky overflow/underflow indication for the control FSM.
module fifo_vc #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [7:0]        umbrales_VCFC,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              FIFO_empty,
  output logic              FIFO_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              FIFO_error
);

  // Threshold compares are done at a width that can hold both the count and
  // a 4-bit threshold.
  localparam int CMP_W = ((ADDR_W + 1) > 4) ? (ADDR_W + 1) : 4;

  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [3:0]        THR_OFF  = 4'd0;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q,    valid_d;
  logic              error_q,    error_d;

  logic              empty_s;
  logic              full_s;
  logic              push_acc;
  logic              pop_acc;
  logic [3:0]        af_thr;
  logic [3:0]        ae_thr;

  // Status flags decoded from the registered count against live thresholds.
  always_comb begin
    af_thr       = umbrales_VCFC[7:4];
    ae_thr       = umbrales_VCFC[3:0];
    empty_s      = (count_q == CNT_ZERO);
    full_s       = (count_q == CNT_FULL);
    almost_full  = (af_thr != THR_OFF) && (CMP_W'(count_q) >= CMP_W'(af_thr));
    almost_empty = (CMP_W'(count_q) <= CMP_W'(ae_thr));
  end

  // Accept logic: a pop needs data present.
  // A push needs room, or a pop accepted in the same cycle that frees one slot.
  always_comb begin
    pop_acc  = pop && !empty_s;
    push_acc = push && (!full_s || pop_acc);
  end

  // Next-state for pointers, count, read data and sticky error.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Overflow: push dropped. Underflow: pop requested on an empty FIFO.
    if ((push && !push_acc) || (pop && !pop_acc)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  // Control and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage array. It has no reset because the count alone defines which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_q;
  assign FIFO_empty = empty_s;
  assign FIFO_full  = full_s;
  assign FIFO_error = error_q;

endmodule

// File: tb/tb_fifo_vc.sv
// tb_fifo_vc: directed self-checking bench for fifo_vc (default parameters).
// The flags vector is {FIFO_empty, FIFO_full, almost_full, almost_empty, FIFO_error, valid_out}.
module tb_fifo_vc;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [7:0] umbrales_VCFC;
  logic [5:0] data_out;
  logic       valid_out;
  logic       FIFO_empty;
  logic       FIFO_full;
  logic       almost_full;
  logic       almost_empty;
  logic       FIFO_error;
  logic [5:0] flags;
  logic [5:0] exp_flags;

  int checks = 0;
  int errors = 0;

  fifo_vc dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .data_in       (data_in),
    .pop           (pop),
    .umbrales_VCFC (umbrales_VCFC),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .FIFO_empty    (FIFO_empty),
    .FIFO_full     (FIFO_full),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .FIFO_error    (FIFO_error)
  );

  assign flags = {FIFO_empty, FIFO_full, almost_full, almost_empty, FIFO_error, valid_out};

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push  = 1'b0;
    pop   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Fill with base+i for i = 0..15, without checks.
  task automatic fill(input int base);
    for (int i = 0; i < 16; i++) begin
      push    = 1'b1;
      data_in = 6'(base + i);
      tick();
    end
    push = 1'b0;
  endtask

  // Expected flags for a count, given error and valid, with AF=12 and AE=3.
  function automatic logic [5:0] fl(input int cnt, input logic err, input logic vld);
    return {cnt == 0, cnt == 16, cnt >= 12, cnt <= 3, err, vld};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (flags !== 6'b100100) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", flags, 6'b100100);
    end
    checks++;
    if (data_out !== 6'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", data_out, 6'h00);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      push    = 1'b1;
      data_in = 6'(i);
      tick();
      exp_flags = fl(i, 1'b0, 1'b0);
      checks++;
      if (flags !== exp_flags) begin
        errors++;
        $display("FAIL fill_flags[%0d]: got %b expected %b", i, flags, exp_flags);
      end
    end
    push = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      pop = 1'b1;
      tick();
      exp_flags = fl(16 - i, 1'b0, 1'b1);
      checks++;
      if (data_out !== 6'(i) || flags !== exp_flags) begin
        errors++;
        $display("FAIL drain[%0d]: got data %h flags %b expected data %h flags %b",
                 i, data_out, flags, 6'(i), exp_flags);
      end
    end
    pop = 1'b0;
    tick();
    checks++;
    if (flags !== 6'b100100 || data_out !== 6'h10) begin
      errors++;
      $display("FAIL drain_idle: got data %h flags %b expected data 10 flags 100100", data_out, flags);
    end
  endtask

  task automatic test_thresholds();
    fill(1);
    umbrales_VCFC = 8'h03;
    #1;
    checks++;
    if (flags !== 6'b010000) begin
      errors++;
      $display("FAIL thr_af_off: got %b expected %b", flags, 6'b010000);
    end
    umbrales_VCFC = 8'hF0;
    #1;
    checks++;
    if (flags !== 6'b011000) begin
      errors++;
      $display("FAIL thr_af15_ae0: got %b expected %b", flags, 6'b011000);
    end
    umbrales_VCFC = 8'hC3;
    #1;
  endtask

  task automatic test_overflow();
    push    = 1'b1;
    data_in = 6'h2A;
    tick();
    push = 1'b0;
    checks++;
    if (flags !== 6'b011010) begin
      errors++;
      $display("FAIL overflow_flags: got %b expected %b", flags, 6'b011010);
    end
    tick();
    checks++;
    if (flags !== 6'b011010) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected %b", flags, 6'b011010);
    end
    for (int i = 1; i <= 16; i++) begin
      pop = 1'b1;
      tick();
      exp_flags = fl(16 - i, 1'b1, 1'b1);
      checks++;
      if (data_out !== 6'(i) || flags !== exp_flags) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: got data %h flags %b expected data %h flags %b",
                 i, data_out, flags, 6'(i), exp_flags);
      end
    end
    pop = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    push    = 1'b1;
    pop     = 1'b1;
    data_in = 6'h15;
    tick();
    push = 1'b0;
    checks++;
    if (flags !== 6'b000110) begin
      errors++;
      $display("FAIL empty_pp_flags: got %b expected %b", flags, 6'b000110);
    end
    tick();
    pop = 1'b0;
    checks++;
    if (data_out !== 6'h15 || flags !== 6'b100111) begin
      errors++;
      $display("FAIL empty_pp_pop: got data %h flags %b expected data 15 flags 100111", data_out, flags);
    end
  endtask

  // Element j of the stream written by test_back_to_back.
  function automatic logic [5:0] b2b_word(input int j);
    return (j < 16) ? 6'(16 + j) : 6'(32 + j - 16);
  endfunction

  task automatic test_back_to_back();
    fill(16);
    for (int k = 0; k < 20; k++) begin
      push    = 1'b1;
      pop     = 1'b1;
      data_in = 6'(32 + k);
      tick();
      checks++;
      if (data_out !== b2b_word(k) || flags !== 6'b011001) begin
        errors++;
        $display("FAIL b2b[%0d]: got data %h flags %b expected data %h flags 011001",
                 k, data_out, flags, b2b_word(k));
      end
    end
    push = 1'b0;
    for (int j = 20; j < 36; j++) begin
      tick();
      checks++;
      if (data_out !== b2b_word(j)) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: got %h expected %h", j, data_out, b2b_word(j));
      end
    end
    pop = 1'b0;
    tick();
    checks++;
    if (flags !== 6'b100100) begin
      errors++;
      $display("FAIL b2b_end: got %b expected %b", flags, 6'b100100);
    end
  endtask

  task automatic test_latency();
    push    = 1'b1;
    data_in = 6'h07;
    tick();
    push = 1'b0;
    pop  = 1'b1;
    checks++;
    if (valid_out !== 1'b0 || FIFO_empty !== 1'b0) begin
      errors++;
      $display("FAIL latency_push: got valid %b empty %b expected valid 0 empty 0", valid_out, FIFO_empty);
    end
    tick();
    pop = 1'b0;
    checks++;
    if (data_out !== 6'h07 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL latency_pop: got data %h valid %b expected data 07 valid 1", data_out, valid_out);
    end
  endtask

  task automatic test_async_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push    = 1'b1;
      data_in = 6'(i);
      tick();
    end
    push = 1'b0;
    checks++;
    if (flags !== 6'b000010) begin
      errors++;
      $display("FAIL areset_pre: got %b expected %b", flags, 6'b000010);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (flags !== 6'b100100 || data_out !== 6'h00) begin
      errors++;
      $display("FAIL areset_now: got data %h flags %b expected data 00 flags 100100", data_out, flags);
    end
    tick();
    reset = 1'b0;
    pop   = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (flags !== 6'b100110) begin
      errors++;
      $display("FAIL areset_discard: got %b expected %b", flags, 6'b100110);
    end
  endtask

  initial begin
    reset         = 1'b1;
    push          = 1'b0;
    pop           = 1'b0;
    data_in       = 6'h00;
    umbrales_VCFC = 8'hC3;
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow();
    do_reset();
    test_empty_push_pop();
    do_reset();
    test_back_to_back();
    test_latency();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
